// File: rtl/tlk2711_dma_rd_arb.sv
// rtl/tlk2711_dma_rd_arb.sv - round-robin sharing of the DMA read-command channel, one command in flight
// Optional watchdog abort is enabled by defining TLK2711_RD_ARB_WDOG_EN.
module tlk2711_dma_rd_arb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DLEN_WIDTH     = 16,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_soft_rst,
  input  logic [NUM_REQ-1:0]                       i_req,
  input  logic [NUM_REQ*(ADDR_WIDTH+DLEN_WIDTH)-1:0] i_cmd_data,
  output logic [NUM_REQ-1:0]                       o_ack,
  output logic [NUM_REQ-1:0]                       o_rd_last,
  output logic                                     o_dma_cmd_req,
  output logic [ADDR_WIDTH+DLEN_WIDTH-1:0]         o_dma_cmd_data,
  input  logic                                     i_dma_cmd_ack,
  input  logic                                     i_dma_rd_last,
  output logic [1:0]                               o_grant_id,
  output logic                                     o_busy,
  output logic                                     o_err,
  output logic                                     o_timeout
);

  localparam int CMD_W = ADDR_WIDTH + DLEN_WIDTH;
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("tlk2711_dma_rd_arb: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t             state, state_n;
  logic [1:0]         rr_ptr, rr_ptr_n, grant_n, winner, next_ptr;
  logic [2:0]         idx;
  logic               found, cmd_req_n, err_n;
  logic [NUM_REQ-1:0] ack_n, rd_last_n;
  logic [CMD_W-1:0]   cmd_data_n;
  logic [IDX_W-1:0]   gidx;

  assign gidx     = o_grant_id[IDX_W-1:0];
  assign next_ptr = (o_grant_id == 2'(NUM_REQ-1)) ? 2'd0 : o_grant_id + 2'd1;
  assign o_busy   = (state != IDLE);

  // Search upward from rr_ptr with wrap; first requester found wins.
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    idx    = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + 3'(i);
      if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
      if (!found && i_req[idx[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[1:0];
      end
    end
  end

`ifdef TLK2711_RD_ARB_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt, wd_cnt_n;
  logic            wd_expire, timeout_n;
  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    grant_n    = o_grant_id;
    cmd_req_n  = o_dma_cmd_req;
    cmd_data_n = o_dma_cmd_data;
    ack_n      = '0;
    rd_last_n  = '0;
    err_n      = o_err;
`ifdef TLK2711_RD_ARB_WDOG_EN
    timeout_n  = 1'b0;
`endif
    if (i_soft_rst) begin
      state_n   = IDLE;
      cmd_req_n = 1'b0;
      rr_ptr_n  = 2'd0;
      err_n     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_dma_rd_last) err_n = 1'b1;
          if (found) begin
            grant_n    = winner;
            cmd_data_n = i_cmd_data[int'(winner)*CMD_W +: CMD_W];
            cmd_req_n  = 1'b1;
            state_n    = ISSUE;
          end
        end
        ISSUE: begin
          if (i_dma_cmd_ack) begin
            cmd_req_n    = 1'b0;
            ack_n[gidx]  = 1'b1;
            rr_ptr_n     = next_ptr;
            state_n      = BUSY;
            if (i_dma_rd_last) begin
              rd_last_n[gidx] = 1'b1;
              state_n         = IDLE;
            end
          end else if (i_dma_rd_last) begin
            err_n = 1'b1;
          end
        end
        BUSY: begin
          if (i_dma_rd_last) begin
            rd_last_n[gidx] = 1'b1;
            state_n         = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
`ifdef TLK2711_RD_ARB_WDOG_EN
      // Abort only when no real event moved the FSM this cycle; release the owner via rd_last.
      if (state != IDLE && state_n == state && wd_expire) begin
        state_n         = IDLE;
        cmd_req_n       = 1'b0;
        timeout_n       = 1'b1;
        rd_last_n[gidx] = 1'b1;
        rr_ptr_n        = next_ptr;
      end
`endif
    end
`ifdef TLK2711_RD_ARB_WDOG_EN
    wd_cnt_n = (state_n == IDLE || state_n != state) ? '0 : wd_cnt + WD_W'(1);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= 2'd0;
      o_grant_id     <= 2'd0;
      o_dma_cmd_req  <= 1'b0;
      o_dma_cmd_data <= '0;
      o_ack          <= '0;
      o_rd_last      <= '0;
      o_err          <= 1'b0;
    end else begin
      state          <= state_n;
      rr_ptr         <= rr_ptr_n;
      o_grant_id     <= grant_n;
      o_dma_cmd_req  <= cmd_req_n;
      o_dma_cmd_data <= cmd_data_n;
      o_ack          <= ack_n;
      o_rd_last      <= rd_last_n;
      o_err          <= err_n;
    end
  end

`ifdef TLK2711_RD_ARB_WDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      wd_cnt    <= wd_cnt_n;
      o_timeout <= timeout_n;
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tlk2711_dma_rd_arb.sv
// tb/tb_tlk2711_dma_rd_arb.sv - scoreboard bench for tlk2711_dma_rd_arb
// Exercises the watchdog path too when TLK2711_RD_ARB_WDOG_EN is defined.
module tb_tlk2711_dma_rd_arb;
  localparam int NR = 2;
  localparam int CW = 48;
`ifdef TLK2711_RD_ARB_WDOG_EN
  localparam int T1_LAST = 10;
`else
  localparam int T1_LAST = 20;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_soft_rst = 1'b0;
  logic [NR-1:0]   i_req;
  logic [CW-1:0]   slice0 = '0, slice1 = '0;
  logic [NR*CW-1:0] i_cmd_data;
  logic [NR-1:0]   o_ack, o_rd_last;
  logic            o_dma_cmd_req;
  logic [CW-1:0]   o_dma_cmd_data;
  logic            i_dma_cmd_ack = 1'b0, i_dma_rd_last = 1'b0;
  logic [1:0]      o_grant_id;
  logic            o_busy, o_err, o_timeout;

  assign i_cmd_data = {slice1, slice0};

  tlk2711_dma_rd_arb #(.ADDR_WIDTH(32), .DLEN_WIDTH(16), .NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .i_soft_rst(i_soft_rst), .i_req(i_req), .i_cmd_data(i_cmd_data),
    .o_ack(o_ack), .o_rd_last(o_rd_last), .o_dma_cmd_req(o_dma_cmd_req),
    .o_dma_cmd_data(o_dma_cmd_data), .i_dma_cmd_ack(i_dma_cmd_ack),
    .i_dma_rd_last(i_dma_rd_last), .o_grant_id(o_grant_id), .o_busy(o_busy),
    .o_err(o_err), .o_timeout(o_timeout));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_chk = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Requesters: each holds i_req while it has commands outstanding, drops on its o_ack.
  int target [NR];
  int done [NR];
  always @(negedge clk)
    for (int k = 0; k < NR; k++) if (o_ack[k]) done[k] <= done[k] + 1;
  always_comb begin
    i_req = '0;
    for (int k = 0; k < NR; k++) i_req[k] = (done[k] != target[k]);
  end

  typedef struct packed { logic [1:0] id; logic [CW-1:0] data; } cmd_t;
  cmd_t exp_cmd[$];
  int   exp_ack[$];
  int   exp_rdl[$];
  logic prev_req = 1'b0;

  task automatic push_cmd(input logic [1:0] id, input logic [CW-1:0] d);
    exp_cmd.push_back({id, d});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_dma_cmd_req && !prev_req) begin
        chk("cmd_expected", 64'(exp_cmd.size() != 0), 1);
        if (exp_cmd.size() != 0) begin
          chk("grant_id", o_grant_id, exp_cmd[0].id);
          chk("cmd_data", o_dma_cmd_data, exp_cmd[0].data);
          void'(exp_cmd.pop_front());
        end
      end
      if (o_ack != '0) begin
        chk("ack_expected", 64'(exp_ack.size() != 0), 1);
        if (exp_ack.size() != 0) begin
          chk("ack_vector", o_ack, 64'(1) << exp_ack[0]);
          void'(exp_ack.pop_front());
        end
      end
      if (o_rd_last != '0) begin
        chk("rd_last_expected", 64'(exp_rdl.size() != 0), 1);
        if (exp_rdl.size() != 0) begin
          chk("rd_last_vector", o_rd_last, 64'(1) << exp_rdl[0]);
          void'(exp_rdl.pop_front());
        end
      end
    end
    prev_req <= o_dma_cmd_req;
  end

  task automatic wait_req(output int c);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_dma_cmd_req) break;
    end
    chk("cmd_req_seen", o_dma_cmd_req, 1);
    c = cyc;
  endtask

  task automatic dma_serve(input int ack_dly, input int last_dly, output int last_cyc);
    repeat (ack_dly) @(negedge clk);
    i_dma_cmd_ack = 1'b1;
    @(negedge clk);
    i_dma_cmd_ack = 1'b0;
    repeat (last_dly - 1) @(negedge clk);
    i_dma_rd_last = 1'b1;
    last_cyc = cyc;
    @(negedge clk);
    i_dma_rd_last = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at time %0t", $time);
    $fatal(1);
  end

  initial begin
    int c0, rq, lst, a;
    repeat (3) @(negedge clk);
    chk("rst_cmd_req", o_dma_cmd_req, 0);
    chk("rst_cmd_data", o_dma_cmd_data, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_rd_last", o_rd_last, 0);
    chk("rst_grant", o_grant_id, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_timeout", o_timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single request from requester 0
    slice0 = {32'h1000_0000, 16'd872};
    slice1 = {32'h2000_0000, 16'd64};
    push_cmd(2'd0, 48'h1000_0000_0368);
    exp_ack.push_back(0); exp_rdl.push_back(0);
    target[0] = target[0] + 1;
    c0 = cyc;
    wait_req(rq);
    chk("req_latency", 64'(rq - c0), 1);
    chk("busy_in_issue", o_busy, 1);
    dma_serve(3, T1_LAST, lst);
    repeat (2) @(negedge clk);
    chk("busy_after_single", o_busy, 0);
    chk("single_acked", 64'(done[0]), 1);

    // Contention: both requesting, two commands each, pointer reset first
    i_soft_rst = 1'b1;
    @(negedge clk);
    i_soft_rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      push_cmd(2'd0, 48'h1000_0000_0368); push_cmd(2'd1, 48'h2000_0000_0040);
      exp_ack.push_back(0); exp_ack.push_back(1);
      exp_rdl.push_back(0); exp_rdl.push_back(1);
    end
    target[0] = target[0] + 2;
    target[1] = target[1] + 2;
    for (int n = 0; n < 4; n++) begin
      wait_req(rq);
      if (n > 0) chk("b2b_gap", 64'(rq - lst), 2);
      dma_serve(1, 3, lst);
    end

    // Ack and rd_last in the same ISSUE cycle
    push_cmd(2'd1, 48'h2000_0000_0040);
    exp_ack.push_back(1); exp_rdl.push_back(1);
    target[1] = target[1] + 1;
    wait_req(rq);
    @(negedge clk);
    i_dma_cmd_ack = 1'b1; i_dma_rd_last = 1'b1;
    @(negedge clk);
    i_dma_cmd_ack = 1'b0; i_dma_rd_last = 1'b0;
    chk("same_ack", o_ack, 2'b10);
    chk("same_rd_last", o_rd_last, 2'b10);
    chk("same_idle", o_busy, 0);
    chk("same_cmd_req", o_dma_cmd_req, 0);
    chk("same_err", o_err, 0);

    // Spurious rd_last while idle
    @(negedge clk);
    i_dma_rd_last = 1'b1;
    @(negedge clk);
    i_dma_rd_last = 1'b0;
    chk("spur_err", o_err, 1);
    chk("spur_rd_last", o_rd_last, 0);
    repeat (3) @(negedge clk);
    chk("err_sticky", o_err, 1);

    // Soft abort during BUSY
    push_cmd(2'd0, 48'h1000_0000_0368);
    exp_ack.push_back(0);
    target[0] = target[0] + 1;
    wait_req(rq);
    @(negedge clk);
    i_dma_cmd_ack = 1'b1;
    @(negedge clk);
    i_dma_cmd_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", o_busy, 1);
    i_soft_rst = 1'b1;
    @(negedge clk);
    i_soft_rst = 1'b0;
    chk("abort_err", o_err, 0);
    chk("abort_cmd_req", o_dma_cmd_req, 0);
    chk("abort_busy", o_busy, 0);
    repeat (4) @(negedge clk);
    push_cmd(2'd0, 48'h1000_0000_0368); push_cmd(2'd1, 48'h2000_0000_0040);
    exp_ack.push_back(0); exp_ack.push_back(1);
    exp_rdl.push_back(0); exp_rdl.push_back(1);
    target[0] = target[0] + 1;
    target[1] = target[1] + 1;
    wait_req(rq);
    dma_serve(0, 2, lst);
    wait_req(rq);
    chk("post_abort_gap", 64'(rq - lst), 2);
    dma_serve(0, 2, lst);

`ifdef TLK2711_RD_ARB_WDOG_EN
    // Watchdog: no rd_last after ack, then the other requester is served
    push_cmd(2'd0, 48'h1000_0000_0368); push_cmd(2'd1, 48'h2000_0000_0040);
    exp_ack.push_back(0); exp_ack.push_back(1);
    exp_rdl.push_back(0); exp_rdl.push_back(1);
    target[0] = target[0] + 1;
    target[1] = target[1] + 1;
    wait_req(rq);
    @(negedge clk);
    i_dma_cmd_ack = 1'b1;
    a = cyc;
    @(negedge clk);
    i_dma_cmd_ack = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_timeout) break;
    end
    chk("wdog_timeout", o_timeout, 1);
    chk("wdog_cycle", 64'(cyc - a), 17);
    chk("wdog_rd_last", o_rd_last, 2'b01);
    wait_req(rq);
    dma_serve(1, 3, lst);
`else
    a = 0;
    chk("no_wdog_timeout", o_timeout, 0);
`endif

    repeat (5) @(negedge clk);
    chk("cmd_queue_drained", 64'(exp_cmd.size()), 0);
    chk("ack_queue_drained", 64'(exp_ack.size()), 0);
    chk("rdl_queue_drained", 64'(exp_rdl.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tlk2711_dma_rd_arb.md
Name: tlk2711_dma_rd_arb

Overview:
- Shares the single DMA read-command channel (saddr/byte-len command, ack, rd_last) between NUM_REQ command generators, e.g. TX channel command blocks.
- Round-robin arbitration; exactly one command in flight at a time.
- The DMA's `rd_last` is routed back only to the requester that owns the current command.
- Sits between the per-channel TX command generators and the DMA read engine.

Parameters:
- ADDR_WIDTH, 32, start-address width.
- DLEN_WIDTH, 16, byte-length width.
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 65535, watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- i_soft_rst  in  1  synchronous abort, one-cycle pulse.
- i_req  in  NUM_REQ  per-requester command request, level.
- i_cmd_data  in  NUM_REQ*(ADDR_WIDTH+DLEN_WIDTH)  requester k occupies slice k; within a slice, high bits = saddr, low bits = byte length.
- o_ack  out  NUM_REQ  one-cycle acknowledge to the granted requester.
- o_rd_last  out  NUM_REQ  one-cycle routed rd_last.
- o_dma_cmd_req  out  1  command request to DMA.
- o_dma_cmd_data  out  ADDR_WIDTH+DLEN_WIDTH  latched command.
- i_dma_cmd_ack  in  1  DMA accepted the command.
- i_dma_rd_last  in  1  DMA finished the current read.
- o_grant_id  out  2  index of the current/last owner.
- o_busy  out  1  high in ISSUE or BUSY.
- o_err  out  1  sticky: spurious rd_last seen.
- o_timeout  out  1  one-cycle pulse on watchdog abort (optional feature only).

Behaviour:
- Reset values (rst): every output 0; state IDLE; rr pointer 0; error flag cleared.
- Requester protocol: hold i_req high with stable data until o_ack. Dropping i_req before o_ack is a protocol violation; the command already latched still completes.
- IDLE:
  - If any i_req is high, pick the winner by round-robin, searching upward from `rr_ptr` with wrap.
  - Latch the winner's slice into o_dma_cmd_data, set o_grant_id, assert o_dma_cmd_req next cycle, go to ISSUE.
  - Latency: i_req rises to o_dma_cmd_req high = 1 cycle.
- ISSUE:
  - o_dma_cmd_req held high and data held stable until i_dma_cmd_ack.
  - On ack: next cycle o_dma_cmd_req=0, o_ack[grant]=1 for exactly 1 cycle, `rr_ptr` = grant+1 mod NUM_REQ, go to BUSY.
- BUSY:
  - Wait for i_dma_rd_last.
  - On it: next cycle o_rd_last[grant]=1 for 1 cycle, go to IDLE.
  - IDLE re-arbitrates in the same cycle it is entered, so the back-to-back gap is rd_last to next o_dma_cmd_req = 2 cycles.
- Ack and rd_last in the same cycle while in ISSUE: both honoured; o_ack and o_rd_last pulse together next cycle; go to IDLE.
- rd_last while IDLE: ignored for routing; sets o_err (sticky until rst or i_soft_rst).
- rd_last while ISSUE without ack: treated the same way (ignored, sets o_err).
- i_dma_cmd_ack outside ISSUE: ignored.
- Simultaneous requests: round-robin is fair. With all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0...
- A requester that is granted and immediately re-requests waits for all other pending requesters first.
- i_soft_rst, from any state:
  - Next cycle: state IDLE, o_dma_cmd_req=0, rr pointer 0, o_err cleared.
  - No o_ack or o_rd_last pulse is generated for the aborted command.
  - i_soft_rst has priority over ack/rd_last arriving in the same cycle.
- rst asserted mid-operation: immediate async clear as listed above; no pulses.
- o_dma_cmd_data holds the last command after completion; it is not cleared.

Optional Feature:
- Macro: TLK2711_RD_ARB_WDOG_EN.
- Defined:
  - A cycle counter runs in ISSUE and BUSY and is cleared on each state entry.
  - On reaching TIMEOUT_CYCLES: abort to IDLE, o_dma_cmd_req=0, o_timeout pulses 1 cycle, and o_rd_last[grant] pulses so the owner is not stalled.
  - `rr_ptr` advances past the aborted owner.
- Not defined: no counter; o_timeout tied 0; the block waits indefinitely.

Test Plan:
- Single request: NUM_REQ=2, i_req=01, slice0={32'h1000_0000,16'd872}, DMA acks 3 cycles after req, rd_last 20 cycles later -> o_dma_cmd_data=48'h1000_0000_0368; o_ack=01 one cycle; o_rd_last=01 one cycle; o_busy low after.
- Contention: i_req=11 held for 4 commands -> grant order 0,1,0,1; each o_ack/o_rd_last goes only to its owner.
- Back-to-back timing: rd_last at cycle N with another request pending -> o_dma_cmd_req high at cycle N+2.
- Same-cycle events: ack and rd_last together in ISSUE -> o_ack and o_rd_last both pulse next cycle, state IDLE. Spurious rd_last while IDLE -> o_err=1, no o_rd_last.
- Abort: i_soft_rst during BUSY -> no o_rd_last pulse; o_err=0; o_dma_cmd_req=0; next request granted to requester 0 first.
- With TLK2711_RD_ARB_WDOG_EN, TIMEOUT_CYCLES=16, no rd_last after ack -> o_timeout pulse 16 cycles after BUSY entry; o_rd_last[grant] pulses; pending request from the other requester is then served.
